// File: rtl/selevy_bus.sv
// -----------------------------------------------------------------------------
// selevy_bus
// Memory-mapped bus fabric: one master port (core load/store unit) is routed
// to one of NSLV slave ports by decoding the top REGION_BITS address bits.
// Slaves insert wait states by delaying s_ack. Unmapped regions and slaves
// that never acknowledge complete with m_err instead of stalling the core.
//
// Ports
//   CLK, RST        clock (rising edge), asynchronous active-high reset
//   m_req           master request level, held until m_ready
//   m_we, m_size    store flag and access size, latched on acceptance
//   m_addr, m_wdata byte address and store data, latched on acceptance
//   m_ready         one-cycle completion pulse
//   m_err           decode error or timeout, valid with m_ready
//   m_rdata         load data, valid with m_ready, held until next completion
//   s_req           one-hot request to the selected slave
//   s_we/s_size/s_addr/s_wdata  latched request fields, broadcast to all slaves
//   s_ack           per-slave completion, only the selected bit is looked at
//   s_rdata         slave i read data at [i*XLEN +: XLEN]
//   busy            high whenever a transaction is in flight
// -----------------------------------------------------------------------------
module selevy_bus #(
    parameter int XLEN        = 32,
    parameter int NSLV        = 4,
    parameter int REGION_BITS = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 m_req,
    input  logic                 m_we,
    input  logic [2:0]           m_size,
    input  logic [XLEN-1:0]      m_addr,
    input  logic [XLEN-1:0]      m_wdata,
    output logic                 m_ready,
    output logic                 m_err,
    output logic [XLEN-1:0]      m_rdata,
    output logic [NSLV-1:0]      s_req,
    output logic                 s_we,
    output logic [2:0]           s_size,
    output logic [XLEN-1:0]      s_addr,
    output logic [XLEN-1:0]      s_wdata,
    input  logic [NSLV-1:0]      s_ack,
    input  logic [NSLV*XLEN-1:0] s_rdata,
    output logic                 busy
);

    localparam int SEL_W = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [REGION_BITS:0] NSLV_LIM = (REGION_BITS + 1)'(NSLV);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            r_state, w_state_next;
    logic [SEL_W-1:0]  r_sel, w_sel_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic [NSLV-1:0]   r_s_req, w_s_req_next;
    logic              r_m_ready, w_m_ready_next;
    logic              r_m_err, w_m_err_next;
    logic [XLEN-1:0]   r_m_rdata, w_m_rdata_next;
    logic              r_s_we, w_s_we_next;
    logic [2:0]        r_s_size, w_s_size_next;
    logic [XLEN-1:0]   r_s_addr, w_s_addr_next;
    logic [XLEN-1:0]   r_s_wdata, w_s_wdata_next;

    // Decode of the incoming address (only meaningful while IDLE).
    logic [REGION_BITS-1:0] w_sel;
    logic                   w_sel_valid;
    logic [NSLV-1:0]        w_hit;
    logic [XLEN-1:0]        w_slv_rdata [NSLV];
    logic                   w_ack;
    logic [XLEN-1:0]        w_ack_rdata;

    assign w_sel       = m_addr[XLEN-1 -: REGION_BITS];
    assign w_sel_valid = ({1'b0, w_sel} < NSLV_LIM);

    generate
        for (genvar gi = 0; gi < NSLV; gi++) begin : g_slv
            assign w_hit[gi]       = (w_sel == REGION_BITS'(gi));
            assign w_slv_rdata[gi] = s_rdata[gi*XLEN +: XLEN];
        end
    endgenerate

    // Only the latched slave's ack and data are ever observed.
    assign w_ack       = s_ack[r_sel];
    assign w_ack_rdata = w_slv_rdata[r_sel];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_sel     <= '0;
            r_cnt     <= '0;
            r_s_req   <= '0;
            r_m_ready <= 1'b0;
            r_m_err   <= 1'b0;
            r_m_rdata <= '0;
            r_s_we    <= 1'b0;
            r_s_size  <= '0;
            r_s_addr  <= '0;
            r_s_wdata <= '0;
        end else begin
            r_state   <= w_state_next;
            r_sel     <= w_sel_next;
            r_cnt     <= w_cnt_next;
            r_s_req   <= w_s_req_next;
            r_m_ready <= w_m_ready_next;
            r_m_err   <= w_m_err_next;
            r_m_rdata <= w_m_rdata_next;
            r_s_we    <= w_s_we_next;
            r_s_size  <= w_s_size_next;
            r_s_addr  <= w_s_addr_next;
            r_s_wdata <= w_s_wdata_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_sel_next     = r_sel;
        w_cnt_next     = r_cnt;
        w_s_req_next   = r_s_req;
        w_m_ready_next = 1'b0;      // ready/err only live for the RESP cycle
        w_m_err_next   = 1'b0;
        w_m_rdata_next = r_m_rdata;
        w_s_we_next    = r_s_we;
        w_s_size_next  = r_s_size;
        w_s_addr_next  = r_s_addr;
        w_s_wdata_next = r_s_wdata;

        case (r_state)
            ST_IDLE: begin
                if (m_req) begin
                    w_s_we_next    = m_we;
                    w_s_size_next  = m_size;
                    w_s_addr_next  = m_addr;
                    w_s_wdata_next = m_wdata;
                    if (w_sel_valid) begin
                        w_sel_next   = w_sel[SEL_W-1:0];
                        w_s_req_next = w_hit;
                        w_cnt_next   = '0;
                        w_state_next = ST_WAIT;
                    end else begin
                        // Unmapped region: answer directly, no slave touched.
                        w_m_ready_next = 1'b1;
                        w_m_err_next   = 1'b1;
                        w_m_rdata_next = '0;
                        w_state_next   = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                // Ack is tested first so an ack on the last allowed cycle wins.
                if (w_ack) begin
                    w_s_req_next   = '0;
                    w_m_ready_next = 1'b1;
                    w_m_rdata_next = w_ack_rdata;
                    w_state_next   = ST_RESP;
                end else if (r_cnt == CNT_LAST) begin
                    w_s_req_next   = '0;
                    w_m_ready_next = 1'b1;
                    w_m_err_next   = 1'b1;
                    w_m_rdata_next = '0;
                    w_state_next   = ST_RESP;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_s_req_next = '0;
            end
        endcase
    end

    assign m_ready = r_m_ready;
    assign m_err   = r_m_err;
    assign m_rdata = r_m_rdata;
    assign s_req   = r_s_req;
    assign s_we    = r_s_we;
    assign s_size  = r_s_size;
    assign s_addr  = r_s_addr;
    assign s_wdata = r_s_wdata;
    assign busy    = (r_state != ST_IDLE);

endmodule
